// File: rtl/ttfir_pkg.sv
// ttfir_pkg: shared state encoding and default parameters for the FIR config controller
package ttfir_pkg;
  localparam int N_TAPS = 3;
  localparam int BW_in = 6;
  localparam logic [BW_in-1:0] SYNC_WORD = 6'h2A;
  localparam int ESC_LEN = 4;
  localparam logic [BW_in-1:0] ESC_WORD = {1'b1, {(BW_in-1){1'b0}}};
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
endpackage

// File: rtl/ttfir_esc_det.sv
// ttfir_esc_det: counts consecutive escape words and flags the one that completes the run
module ttfir_esc_det
  import ttfir_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [BW_in-1:0] data,
  output logic             hit
);
  localparam int CW = $clog2(ESC_LEN + 1);
  logic [CW-1:0] cnt;
  logic is_esc;
  assign is_esc = data == ESC_WORD;
  assign hit = en && is_esc && cnt == CW'(ESC_LEN - 1);
  always_ff @(posedge clk)
    if (rst || !en || hit) cnt <= '0;
    else cnt <= is_esc ? cnt + 1'b1 : '0;
endmodule

// File: rtl/ttfir_cfg_ctrl.sv
// ttfir_cfg_ctrl: time-shares the pin bus between atomic coefficient loads and sample streaming
module ttfir_cfg_ctrl
  import ttfir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BW_in-1:0]        pin_data,
  output logic [BW_in-1:0]        x_out,
  output logic                    x_valid,
  output logic [N_TAPS*BW_in-1:0] coef_flat,
  output logic                    flush,
  output logic [1:0]              mode
);
  localparam int IW = $clog2(N_TAPS);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [BW_in-1:0] shadow [N_TAPS];
  logic [N_TAPS*BW_in-1:0] commit;
  logic last, hit, run;
  assign run = state == RUN;
  assign last = idx == IW'(N_TAPS - 1);
  assign mode = state;
  ttfir_esc_det u_esc (.clk(clk), .rst(rst), .en(run), .data(pin_data), .hit(hit));
  // the final word bypasses the shadow so the whole set lands in one edge
  always_comb begin
    commit = '0;
    for (int i = 0; i < N_TAPS; i++)
      commit[i*BW_in +: BW_in] = (i == int'(idx)) ? pin_data : shadow[i];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (pin_data == SYNC_WORD) ? LOAD : IDLE;
      LOAD: state_nx = last ? RUN : LOAD;
      RUN: state_nx = hit ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      x_out <= '0;
      x_valid <= 1'b0;
      flush <= 1'b0;
      coef_flat <= '0;
      for (int i = 0; i < N_TAPS; i++) shadow[i] <= '0;
    end else begin
      state <= state_nx;
      flush <= run && hit;
      x_valid <= run && !hit;
      x_out <= (run && !hit) ? pin_data : '0;
      if (state == LOAD) begin
        shadow[idx] <= pin_data;
        idx <= last ? '0 : idx + 1'b1;
        if (last) coef_flat <= commit;
      end else idx <= '0;
    end
  end
endmodule

// File: tb/tb_ttfir_cfg_ctrl.sv
// tb_ttfir_cfg_ctrl: directed plan plus random pin traffic against a queue-based reference model
module tb_ttfir_cfg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] pin_data = '0;
  logic [5:0] x_out;
  logic x_valid;
  logic [17:0] coef_flat;
  logic flush;
  logic [1:0] mode;
  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  logic [5:0] m_x = '0;
  logic m_v = 1'b0;
  logic m_flush = 1'b0;
  logic [17:0] m_coef = '0;
  logic [5:0] m_q[$];
  int m_esc = 0;

  ttfir_cfg_ctrl dut (.clk(clk), .rst(rst), .pin_data(pin_data), .x_out(x_out),
    .x_valid(x_valid), .coef_flat(coef_flat), .flush(flush), .mode(mode));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic [5:0] p);
    if (r) begin
      m_mode = 0; m_x = '0; m_v = 0; m_flush = 0; m_coef = '0; m_esc = 0;
      m_q.delete();
    end else if (m_mode == 0) begin
      m_x = '0; m_v = 0; m_flush = 0;
      if (p == 6'h2A) begin m_mode = 1; m_q.delete(); end
    end else if (m_mode == 1) begin
      m_x = '0; m_v = 0; m_flush = 0;
      m_q.push_back(p);
      if (m_q.size() == 3) begin
        for (int i = 0; i < 3; i++) m_coef[i*6 +: 6] = m_q[i];
        m_q.delete();
        m_mode = 2;
      end
    end else begin
      if (p == 6'h20 && m_esc == 3) begin
        m_mode = 0; m_x = '0; m_v = 0; m_flush = 1; m_esc = 0;
      end else begin
        m_x = p; m_v = 1; m_flush = 0;
        m_esc = (p == 6'h20) ? m_esc + 1 : 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [5:0] p);
    rst = r;
    pin_data = p;
    @(posedge clk);
    model(r, p);
    #1;
    check("mode", 32'(mode), 32'(m_mode));
    check("x_out", 32'(x_out), 32'(m_x));
    check("x_valid", 32'(x_valid), 32'(m_v));
    check("flush", 32'(flush), 32'(m_flush));
    check("coef_flat", 32'(coef_flat), 32'(m_coef));
  endtask

  initial begin
    logic [5:0] p;
    step(1, 0); step(1, 0);
    check("reset_coef", 32'(coef_flat), 32'h0);
    repeat (5) step(0, 6'h15);
    check("idle_mode", 32'(mode), 32'd0);
    step(0, 6'h2A); step(0, 1); step(0, 2);
    check("partial_coef", 32'(coef_flat), 32'h0);
    step(0, 3);
    check("load_coef", 32'(coef_flat), 32'h03081);
    check("load_mode", 32'(mode), 32'd2);
    check("load_valid", 32'(x_valid), 32'd0);
    step(0, 5);
    check("stream_x0", 32'(x_out), 32'd5);
    step(0, 6'h3F);
    check("stream_x1", 32'(x_out), 32'h3F);
    repeat (3) step(0, 6'h20);
    step(0, 6'h05);
    check("broken_esc_mode", 32'(mode), 32'd2);
    repeat (3) step(0, 6'h20);
    check("esc_fwd_valid", 32'(x_valid), 32'd1);
    step(0, 6'h20);
    check("esc_flush", 32'(flush), 32'd1);
    check("esc_mode", 32'(mode), 32'd0);
    check("esc_coef_kept", 32'(coef_flat), 32'h03081);
    step(0, 0);
    check("flush_one_cycle", 32'(flush), 32'd0);
    step(0, 6'h2A); step(0, 7); step(1, 0);
    check("midload_rst_coef", 32'(coef_flat), 32'h0);
    step(0, 6'h2A); step(0, 9); step(0, 9); step(0, 9);
    check("reload_coef", 32'(coef_flat), 32'h09249);
    repeat (4) step(0, 6'h20);
    step(0, 6'h2A); step(0, 6'h2A); step(0, 6'h20); step(0, 6'h2A);
    check("sync_as_data", 32'(coef_flat), 32'h2A82A);
    check("sync_as_data_mode", 32'(mode), 32'd2);
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(9))
        0, 1: p = 6'h2A;
        2, 3, 4, 5: p = 6'h20;
        default: p = 6'($urandom);
      endcase
      step($urandom_range(99) == 0, p);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ttfir_cfg_ctrl.md
# ttfir_cfg_ctrl

Configuration and sequencing controller for the Tiny Tapeout FIR datapath. The top level has only six data input pins, so this block time-shares them between coefficient loading and sample streaming. It captures a sync word and N_TAPS coefficients, commits them atomically to the FIR core, then forwards samples with a valid strobe. An in-band escape sequence returns it to configuration and flushes the FIR delay line. It sits between the top-level pin decode and the FIR core.

## Interface
- N_TAPS, 3, number of FIR taps / coefficient words per load
- BW_in, 6, width of pin data, samples and coefficients
- SYNC_WORD, 6'h2A, word that starts a coefficient load from IDLE
- ESC_LEN, 4, consecutive escape samples (value −2^(BW_in−1), 6'h20) that end RUN

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pin_data  input  BW_in  signed pin word, sampled every edge
- x_out  output  BW_in  signed sample to FIR core, registered
- x_valid  output  1  x_out is a live sample this cycle
- coef_flat  output  N_TAPS*BW_in  committed coefficients, coef[i] at bits [i*BW_in +: BW_in]
- flush  output  1  one-cycle pulse: FIR core clears its delay line
- mode  output  2  current state: 0 IDLE, 1 LOAD, 2 RUN

## Operation
- Reset: state IDLE, x_out 0, x_valid 0, coef_flat 0, flush 0, tap index 0, escape count 0, shadow coefficients 0.
- IDLE: pin_data == SYNC_WORD → LOAD, tap index 0. Other values are ignored. x_out and x_valid are held at 0.
- LOAD: each edge writes pin_data into shadow[idx] and increments idx. SYNC_WORD and escape values are ordinary coefficients here. On the edge that captures idx == N_TAPS−1:
  - coef_flat <= shadow with that final word included, committed in a single edge
  - state <= RUN, idx <= 0
- coef_flat changes only on that commit edge or on reset. A partial load never reaches coef_flat.
- RUN, on each edge:
  - pin_data == ESC and esc_cnt == ESC_LEN−1: state <= IDLE, x_out <= 0, x_valid <= 0, flush <= 1, esc_cnt <= 0. This final escape word is not forwarded.
  - otherwise: x_out <= pin_data, x_valid <= 1, esc_cnt <= (pin_data == ESC) ? esc_cnt+1 : 0.
- flush is high for exactly one cycle after the escape edge, then returns to 0.
- Committed coefficients are retained across escape and IDLE, and are replaced only by the next complete load.

## Timing
- Pin to x_out latency: 1 cycle (registered).
- Commit edge: mode reads 2 after it; x_valid stays 0 for that cycle; the first sample is forwarded on the following edge.
- Escape with ESC_LEN=4: the first 3 escape words are forwarded with x_valid=1. On the 4th edge, mode goes to 0, flush goes to 1 and x_valid goes to 0, all together.
- A non-escape word breaks the run: counter clears, and a new escape run needs ESC_LEN fresh consecutive words.
- rst takes priority over every transition. Asserting it mid-LOAD discards the shadow registers and the index. Asserting it mid-RUN clears coef_flat to 0.
- A sync word arriving in the cycle right after the escape edge starts a new load; there are no dead cycles.

## Structure
- Package ttfir_pkg holds:
  - state encoding (IDLE/LOAD/RUN as 2-bit constants matching mode)
  - default SYNC_WORD, ESC_LEN, N_TAPS, BW_in
- Sub-module ttfir_esc_det holds the escape comparator and saturating counter. Ports: clk, rst, en (RUN), data, hit (combinational, count would reach ESC_LEN).
- Shadow array, tap index and FSM stay in ttfir_cfg_ctrl.

## Test plan
1. Reset: rst high 2 cycles → mode 0, x_out 0, x_valid 0, coef_flat 18'h0, flush 0. Then drive 6'h15 ×5 → still mode 0, x_valid 0.
2. Load: pins 6'h2A, 1, 2, 3 on consecutive edges.
   - coef_flat stays 0 until the 4th edge.
   - After the 4th edge: coef_flat = 18'h03081, mode 2, x_valid 0.
3. Stream: after load, pins 5 then 6'h3F.
   - x_out = 5, x_valid 1 one cycle later.
   - Then x_out = 6'h3F (−1).
4. Escape: in RUN, pins 6'h20 ×3 then 6'h05.
   - All four are forwarded and mode stays 2.
   - Then 6'h20 ×4: the first three are forwarded; after the 4th, mode 0, flush 1 for exactly one cycle, x_valid 0, coef_flat still 18'h03081.
5. Reset mid-LOAD: pins 6'h2A, 7, then rst → mode 0, coef_flat 0. Then 6'h2A, 9, 9, 9 → coef_flat = 18'h09249.
6. Sync value as data: pins 6'h2A, 6'h2A, 6'h20, 6'h2A → coef_flat = {6'h2A, 6'h20, 6'h2A} = 18'h2A82A, mode 2.
